interrupt_controller: RTL and testbench

- Prioritising interrupt controller that sequences the fetch-stage program counter between normal flow, ISR entry and return.
- Captures up to NUM_IRQ requests and selects the highest-priority unmasked one.
- Drives the PC's `interrupt`/`pc_isr` load path, saves the return address, and restores it when the ISR executes its return.
- Respects the pipeline stall so no redirect is ever lost.

---
 rtl/interrupt_controller_pkg.sv | 35 +++
 rtl/interrupt_controller_if.sv | 37 +++
 rtl/interrupt_controller_prio_enc.sv | 32 +++
 rtl/interrupt_controller.sv | 137 +++++++++++++
 tb/tb_interrupt_controller.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/interrupt_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : simplerisc_irq_pkg
// Description : Shared definitions for the interrupt controller: FSM state
//               encoding, request-index width, default vector table layout
//               and the vector-address helper.
// Config      : none (IRQ_EDGE_EN affects interrupt_controller only)
// Revision    : 1.0 - initial release
// ============================================================================
package simplerisc_irq_pkg;

    // Width of a request index; 4 bits covers up to 16 request lines.
    localparam int IRQ_ID_W = 4;

    typedef logic [1:0] irq_state_t;

    localparam irq_state_t ST_IDLE    = 2'd0;
    localparam irq_state_t ST_TAKE    = 2'd1;
    localparam irq_state_t ST_SERVICE = 2'd2;
    localparam irq_state_t ST_RETURN  = 2'd3;

    localparam logic [31:0] C_ISR_BASE_DEFAULT   = 32'h0000_0100;
    localparam logic [31:0] C_ISR_STRIDE_DEFAULT = 32'h0000_0010;

    // Vector address of ISR <id>; wraps modulo 2^32 by construction.
    function automatic logic [31:0] isr_vector(
        input logic [31:0]         base,
        input logic [31:0]         stride,
        input logic [IRQ_ID_W-1:0] id
    );
        return base + stride * {{(32-IRQ_ID_W){1'b0}}, id};
    endfunction

endpackage
`default_nettype wire

// File: rtl/interrupt_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : interrupt_controller_if
// Description : Bundle between the CPU fetch/decode side (master) and the
//               interrupt controller (slave).
//   master drives : irq_req, irq_mask, pc, add_stall, reti
//   slave drives  : interrupt, pc_isr, epc, irq_ack, irq_active, active_id
// Revision    : 1.0 - initial release
// ============================================================================
interface interrupt_controller_if
    import simplerisc_irq_pkg::*;
#(
    parameter int NUM_IRQ = 4
);
    logic [NUM_IRQ-1:0]  irq_req;
    logic [NUM_IRQ-1:0]  irq_mask;
    logic [31:0]         pc;
    logic                add_stall;
    logic                reti;
    logic                interrupt;
    logic [31:0]         pc_isr;
    logic [31:0]         epc;
    logic [NUM_IRQ-1:0]  irq_ack;
    logic                irq_active;
    logic [IRQ_ID_W-1:0] active_id;

    modport master (
        output irq_req, irq_mask, pc, add_stall, reti,
        input  interrupt, pc_isr, epc, irq_ack, irq_active, active_id
    );

    modport slave (
        input  irq_req, irq_mask, pc, add_stall, reti,
        output interrupt, pc_isr, epc, irq_ack, irq_active, active_id
    );
endinterface
`default_nettype wire

// File: rtl/interrupt_controller_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : irq_prio_enc
// Description : Combinational lowest-index-wins priority encoder.
//   i_req   in  NUM_IRQ   request vector, bit 0 highest priority
//   o_valid out 1         any request set
//   o_idx   out IRQ_ID_W  index of the lowest set bit (0 when none)
// Revision    : 1.0 - initial release
// ============================================================================
module irq_prio_enc
    import simplerisc_irq_pkg::*;
#(
    parameter int NUM_IRQ = 4
) (
    input  wire [NUM_IRQ-1:0]  i_req,
    output logic               o_valid,
    output logic [IRQ_ID_W-1:0] o_idx
);

    always_comb begin
        o_valid = |i_req;
        o_idx   = '0;
        // Scan high to low so the last (lowest) set bit wins.
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx = IRQ_ID_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/interrupt_controller.sv
`default_nettype none
// ============================================================================
// Module      : interrupt_controller
// Description : Prioritising interrupt controller sequencing the fetch PC
//               between normal flow, ISR entry and ISR return.
//   clk  in   system clock, rising edge
//   rst  in   asynchronous, active-low reset
//   bus  slave modport of interrupt_controller_if
//        (irq_req/irq_mask/pc/add_stall/reti in;
//         interrupt/pc_isr/epc/irq_ack/irq_active/active_id out)
// Config      : IRQ_EDGE_EN - when defined, requests are rising-edge
//               detected and latched in a pending register; otherwise the
//               pending set is the request level itself.
// Revision    : 1.0 - initial release
// ============================================================================
module interrupt_controller
    import simplerisc_irq_pkg::*;
#(
    parameter int          NUM_IRQ    = 4,
    parameter logic [31:0] ISR_BASE   = C_ISR_BASE_DEFAULT,
    parameter logic [31:0] ISR_STRIDE = C_ISR_STRIDE_DEFAULT
) (
    input wire                    clk,
    input wire                    rst,
    interrupt_controller_if.slave bus
);

    irq_state_t          r_state;
    logic [NUM_IRQ-1:0]  w_pending;
    logic [NUM_IRQ-1:0]  w_eligible;
    logic [NUM_IRQ-1:0]  w_ack;
    logic [NUM_IRQ-1:0]  r_sel;
    logic                w_win_valid;
    logic [IRQ_ID_W-1:0] w_win_idx;
    logic                r_interrupt;
    logic                r_active;
    logic [31:0]         r_pc_isr;
    logic [31:0]         r_epc;
    logic [IRQ_ID_W-1:0] r_active_id;

    // The winner's one-hot is registered on entry to TAKE; the stall only
    // gates it, so the ack lands exactly in the cycle the PC takes the
    // redirect and never during a stalled TAKE cycle.
    assign w_ack = (r_state == ST_TAKE && !bus.add_stall) ? r_sel : '0;

`ifdef IRQ_EDGE_EN
    logic [NUM_IRQ-1:0] r_req_d;
    logic [NUM_IRQ-1:0] r_pending;

    // Set wins over clear so an edge coincident with its own ack is kept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_req_d   <= '0;
            r_pending <= '0;
        end else begin
            r_req_d   <= bus.irq_req;
            r_pending <= (r_pending & ~w_ack) | (bus.irq_req & ~r_req_d);
        end
    end

    assign w_pending = r_pending;
`else
    // Level mode: the requester holds the line until acked.
    assign w_pending = bus.irq_req;
`endif

    assign w_eligible = w_pending & ~bus.irq_mask;

    irq_prio_enc #(
        .NUM_IRQ (NUM_IRQ)
    ) u_prio_enc (
        .i_req   (w_eligible),
        .o_valid (w_win_valid),
        .o_idx   (w_win_idx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_interrupt <= 1'b0;
            r_pc_isr    <= '0;
            r_epc       <= '0;
            r_sel       <= '0;
            r_active    <= 1'b0;
            r_active_id <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Winner is frozen here; later mask changes cannot abort.
                    if (w_win_valid) begin
                        r_state     <= ST_TAKE;
                        r_interrupt <= 1'b1;
                        r_active_id <= w_win_idx;
                        r_sel       <= NUM_IRQ'(1) << w_win_idx;
                        r_pc_isr    <= isr_vector(ISR_BASE, ISR_STRIDE, w_win_idx);
                    end
                end
                ST_TAKE: begin
                    // The stalled PC still fetches from pc, so capture it
                    // only in the accepting cycle.
                    if (!bus.add_stall) begin
                        r_state     <= ST_SERVICE;
                        r_interrupt <= 1'b0;
                        r_epc       <= bus.pc;
                        r_active    <= 1'b1;
                    end
                end
                ST_SERVICE: begin
                    if (bus.reti) begin
                        r_state     <= ST_RETURN;
                        r_interrupt <= 1'b1;
                        r_pc_isr    <= r_epc;
                        r_active    <= 1'b0;
                    end
                end
                ST_RETURN: begin
                    if (!bus.add_stall) begin
                        r_state     <= ST_IDLE;
                        r_interrupt <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.interrupt  = r_interrupt;
    assign bus.pc_isr     = r_pc_isr;
    assign bus.epc        = r_epc;
    assign bus.irq_ack    = w_ack;
    assign bus.irq_active = r_active;
    assign bus.active_id  = r_active_id;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_interrupt_controller
// Description : Self-checking bench for interrupt_controller (level mode).
//               A per-cycle vector table drives inputs and lists the outputs
//               expected in that cycle; hand-written sequences cover the
//               asynchronous reset during entry and re-entry after release.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_interrupt_controller;

    localparam int NUM_IRQ = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    interrupt_controller_if #(.NUM_IRQ(NUM_IRQ)) bus ();

    interrupt_controller #(
        .NUM_IRQ    (NUM_IRQ),
        .ISR_BASE   (32'h0000_0100),
        .ISR_STRIDE (32'h0000_0010)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  mask;
        logic [31:0] pc;
        logic        stall;
        logic        reti;
        logic        e_int;
        logic [31:0] e_isr;
        logic [31:0] e_epc;
        logic [3:0]  e_ack;
        logic        e_act;
        logic [3:0]  e_id;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic add(
        input logic [3:0] req, input logic [3:0] mask, input logic [31:0] pc,
        input logic stall, input logic reti,
        input logic e_int, input logic [31:0] e_isr, input logic [31:0] e_epc,
        input logic [3:0] e_ack, input logic e_act, input logic [3:0] e_id
    );
        vec_t v;
        v.req = req;     v.mask = mask;   v.pc = pc;
        v.stall = stall; v.reti = reti;
        v.e_int = e_int; v.e_isr = e_isr; v.e_epc = e_epc;
        v.e_ack = e_ack; v.e_act = e_act; v.e_id = e_id;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(
        input string tag, input logic e_int, input logic [31:0] e_isr,
        input logic [31:0] e_epc, input logic [3:0] e_ack, input logic e_act,
        input logic [3:0] e_id
    );
        chk({tag, " interrupt"},  32'(bus.interrupt),  32'(e_int));
        chk({tag, " pc_isr"},     bus.pc_isr,          e_isr);
        chk({tag, " epc"},        bus.epc,             e_epc);
        chk({tag, " irq_ack"},    32'(bus.irq_ack),    32'(e_ack));
        chk({tag, " irq_active"}, 32'(bus.irq_active), 32'(e_act));
        chk({tag, " active_id"},  32'(bus.active_id),  32'(e_id));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;

        rst           = 1'b0;
        bus.irq_req   = '0;
        bus.irq_mask  = '0;
        bus.pc        = '0;
        bus.add_stall = 1'b0;
        bus.reti      = 1'b0;

        //   req      mask     pc          st rt  int isr         epc         ack      act id
        // single request on line 2
        add(4'b0100, 4'b0000, 32'h20,  0, 0,  0, 32'h0,   32'h0,  4'b0000, 0, 4'd0);
        add(4'b0100, 4'b0000, 32'h20,  0, 0,  1, 32'h120, 32'h0,  4'b0100, 0, 4'd2);
        add(4'b0000, 4'b0000, 32'h120, 0, 0,  0, 32'h120, 32'h20, 4'b0000, 1, 4'd2);
        add(4'b0000, 4'b0000, 32'h124, 0, 1,  0, 32'h120, 32'h20, 4'b0000, 1, 4'd2);
        add(4'b0000, 4'b0000, 32'h128, 0, 0,  1, 32'h20,  32'h20, 4'b0000, 0, 4'd2);
        // spurious reti in IDLE
        add(4'b0000, 4'b0000, 32'h20,  0, 1,  0, 32'h20,  32'h20, 4'b0000, 0, 4'd2);
        add(4'b0000, 4'b0000, 32'h24,  0, 0,  0, 32'h20,  32'h20, 4'b0000, 0, 4'd2);
        // simultaneous 1011 with line 0 masked: line 1 then line 3
        add(4'b1011, 4'b0001, 32'h30,  0, 0,  0, 32'h20,  32'h20, 4'b0000, 0, 4'd2);
        add(4'b1011, 4'b0001, 32'h30,  0, 0,  1, 32'h110, 32'h20, 4'b0010, 0, 4'd1);
        add(4'b1001, 4'b0001, 32'h110, 0, 0,  0, 32'h110, 32'h30, 4'b0000, 1, 4'd1);
        add(4'b1001, 4'b0001, 32'h114, 0, 1,  0, 32'h110, 32'h30, 4'b0000, 1, 4'd1);
        add(4'b1001, 4'b0001, 32'h118, 0, 0,  1, 32'h30,  32'h30, 4'b0000, 0, 4'd1);
        add(4'b1001, 4'b0001, 32'h30,  0, 0,  0, 32'h30,  32'h30, 4'b0000, 0, 4'd1);
        add(4'b1001, 4'b0001, 32'h34,  0, 0,  1, 32'h130, 32'h30, 4'b1000, 0, 4'd3);
        add(4'b0001, 4'b0001, 32'h130, 0, 1,  0, 32'h130, 32'h34, 4'b0000, 1, 4'd3);
        // stall (and ignored reti) during RETURN
        add(4'b0001, 4'b0001, 32'h134, 1, 1,  1, 32'h34,  32'h34, 4'b0000, 0, 4'd3);
        add(4'b0001, 4'b0001, 32'h134, 0, 0,  1, 32'h34,  32'h34, 4'b0000, 0, 4'd3);
        // masked request does not enter
        add(4'b0001, 4'b0001, 32'h34,  0, 0,  0, 32'h34,  32'h34, 4'b0000, 0, 4'd3);
        add(4'b0000, 4'b0000, 32'h38,  0, 0,  0, 32'h34,  32'h34, 4'b0000, 0, 4'd3);
        // line 0, stall 3 cycles in TAKE, mask raised after entry, reti ignored
        add(4'b0001, 4'b0000, 32'h40,  0, 0,  0, 32'h34,  32'h34, 4'b0000, 0, 4'd3);
        add(4'b0001, 4'b0001, 32'h40,  1, 0,  1, 32'h100, 32'h34, 4'b0000, 0, 4'd0);
        add(4'b0001, 4'b0001, 32'h44,  1, 1,  1, 32'h100, 32'h34, 4'b0000, 0, 4'd0);
        add(4'b0001, 4'b0001, 32'h48,  1, 0,  1, 32'h100, 32'h34, 4'b0000, 0, 4'd0);
        add(4'b0001, 4'b0001, 32'h44,  0, 0,  1, 32'h100, 32'h34, 4'b0001, 0, 4'd0);
        add(4'b0000, 4'b0000, 32'h100, 0, 0,  0, 32'h100, 32'h44, 4'b0000, 1, 4'd0);
        // return to 0x44
        add(4'b0000, 4'b0000, 32'h104, 0, 1,  0, 32'h100, 32'h44, 4'b0000, 1, 4'd0);
        add(4'b0000, 4'b0000, 32'h108, 0, 0,  1, 32'h44,  32'h44, 4'b0000, 0, 4'd0);
        add(4'b0000, 4'b0000, 32'h44,  0, 0,  0, 32'h44,  32'h44, 4'b0000, 0, 4'd0);

        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 1'b0, 32'h0, 32'h0, 4'b0000, 1'b0, 4'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            bus.irq_req   = vecs[i].req;
            bus.irq_mask  = vecs[i].mask;
            bus.pc        = vecs[i].pc;
            bus.add_stall = vecs[i].stall;
            bus.reti      = vecs[i].reti;
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].e_int, vecs[i].e_isr,
                    vecs[i].e_epc, vecs[i].e_ack, vecs[i].e_act, vecs[i].e_id);
            @(posedge clk);
            #1;
        end

        // Reset asserted while in TAKE: outputs drop without a clock edge.
        bus.irq_req   = 4'b0010;
        bus.irq_mask  = 4'b0000;
        bus.pc        = 32'h50;
        bus.add_stall = 1'b0;
        bus.reti      = 1'b0;
        @(posedge clk);
        #1;
        chk("pre-reset interrupt", 32'(bus.interrupt), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk_all("async reset", 1'b0, 32'h0, 32'h0, 4'b0000, 1'b0, 4'd0);
        @(posedge clk);
        #1;
        chk("held reset interrupt", 32'(bus.interrupt), 32'd0);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_all("re-entry", 1'b1, 32'h110, 32'h0, 4'b0010, 1'b0, 4'd1);

        cyc = 0;
        while (bus.irq_active !== 1'b1 && cyc < 8) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.irq_req = 4'b0000;
        chk("re-entry reached service", 32'(bus.irq_active), 32'd1);
        chk("re-entry epc", bus.epc, 32'h50);

        bus.reti = 1'b1;
        @(posedge clk);
        #1;
        bus.reti = 1'b0;
        chk("re-entry return interrupt", 32'(bus.interrupt), 32'd1);
        chk("re-entry return pc_isr", bus.pc_isr, 32'h50);
        @(posedge clk);
        #1;
        chk("re-entry idle interrupt", 32'(bus.interrupt), 32'd0);
        chk("re-entry idle irq_active", 32'(bus.irq_active), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
